signal_conflict_monitor: RTL and testbench

- Independent safety monitor on the receiving end of the intersection controller's lamp outputs.
- Each cycle it samples the four approach lamp codes and the one-hot pedestrian walk vector.
- It checks them against the signalling rules: single green, legal codes, legal colour sequence, minimum green and exact yellow dwell, one-hot walk.
- On the first violation it latches a sticky fault with a code and approach index, which downstream logic uses to force flashing-red.

---
 rtl/signal_conflict_monitor.sv | 178 +++++++++++++++++
 tb/tb_signal_conflict_monitor.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/signal_conflict_monitor.sv
// Independent safety monitor for intersection lamp outputs. It checks the lamps against the
// signalling rules and latches the first violation as a sticky fault with a cause code and approach.
module signal_conflict_monitor #(
  parameter int Y_TIME    = 2,
  parameter int MIN_GREEN = 10,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [1:0] right,
  input  logic [1:0] up,
  input  logic [1:0] down,
  input  logic [1:0] left,
  input  logic [3:0] walk,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] fault_dir,
  output logic [1:0] active_dir,
  output logic       active_valid
);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_FAULT} state_e;

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;
  localparam logic [1:0] BAD    = 2'd3;

  state_e           state_q, state_d;
  logic [1:0]       code [4];
  logic [1:0]       prev_q [4];
  logic [CNT_W-1:0] dwell_q [4];
  logic [3:0]       entrySeen_q;

  logic       fault_q, fault_d;
  logic [2:0] faultCode_q, faultCode_d;
  logic [1:0] faultDir_q, faultDir_d;
  logic [1:0] activeDir_q, activeDir_d;
  logic       activeValid_q, activeValid_d;

  logic [3:0] green, illegal, badTrans, shortGreen, badYellow;
  logic       walkBad, oneGreen, multiGreen;
  logic [2:0] vioCode;
  logic [1:0] vioDir;

  assign code[0] = right;
  assign code[1] = up;
  assign code[2] = down;
  assign code[3] = left;

  function automatic logic [1:0] lowestIdx(input logic [3:0] v);
    lowestIdx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) lowestIdx = 2'(i);
    end
  endfunction

  // Duration rules only judge dwells whose start was actually observed (entrySeen).
  always_comb begin
    green      = '0;
    illegal    = '0;
    badTrans   = '0;
    shortGreen = '0;
    badYellow  = '0;
    for (int i = 0; i < 4; i++) begin
      green[i]   = (code[i] == GREEN);
      illegal[i] = (code[i] == BAD);
      if (code[i] != prev_q[i]) begin
        badTrans[i] = !((prev_q[i] == RED    && code[i] == GREEN)  ||
                        (prev_q[i] == GREEN  && code[i] == YELLOW) ||
                        (prev_q[i] == YELLOW && code[i] == RED));
        shortGreen[i] = entrySeen_q[i] && prev_q[i] == GREEN && code[i] == YELLOW &&
                        (dwell_q[i] < CNT_W'(MIN_GREEN));
        badYellow[i]  = entrySeen_q[i] && prev_q[i] == YELLOW && code[i] == RED &&
                        (dwell_q[i] != CNT_W'(Y_TIME));
      end
    end
    walkBad    = (walk == 4'd0) || ((walk & (walk - 4'd1)) != 4'd0);
    oneGreen   = $onehot(green);
    multiGreen = (green != 4'd0) && !oneGreen;
  end

  always_comb begin
    vioCode = 3'd0;
    vioDir  = 2'd0;
    if (multiGreen) begin
      vioCode = 3'd1;
      vioDir  = lowestIdx(green);
    end else if (illegal != 4'd0) begin
      vioCode = 3'd2;
      vioDir  = lowestIdx(illegal);
    end else if (badTrans != 4'd0) begin
      vioCode = 3'd3;
      vioDir  = lowestIdx(badTrans);
    end else if (shortGreen != 4'd0) begin
      vioCode = 3'd4;
      vioDir  = lowestIdx(shortGreen);
    end else if (badYellow != 4'd0) begin
      vioCode = 3'd5;
      vioDir  = lowestIdx(badYellow);
    end else if (walkBad) begin
      vioCode = 3'd6;
      vioDir  = 2'd0;
    end
  end

  always_comb begin
    state_d       = state_q;
    fault_d       = fault_q;
    faultCode_d   = faultCode_q;
    faultDir_d    = faultDir_q;
    activeDir_d   = activeDir_q;
    activeValid_d = activeValid_q;
    unique case (state_q)
      S_INIT: begin
        state_d       = S_RUN;
        activeValid_d = oneGreen;
        if (oneGreen) activeDir_d = lowestIdx(green);
      end
      S_RUN: begin
        if (oneGreen) activeDir_d = lowestIdx(green);
        activeValid_d = oneGreen && (vioCode == 3'd0);
        if (vioCode != 3'd0) begin
          state_d     = S_FAULT;
          fault_d     = 1'b1;
          faultCode_d = vioCode;
          faultDir_d  = vioDir;
        end
      end
      S_FAULT: begin
        activeValid_d = 1'b0;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q       <= S_INIT;
      fault_q       <= 1'b0;
      faultCode_q   <= 3'd0;
      faultDir_q    <= 2'd0;
      activeDir_q   <= 2'd0;
      activeValid_q <= 1'b0;
      entrySeen_q   <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        prev_q[i]  <= RED;
        dwell_q[i] <= CNT_W'(1);
      end
    end else begin
      state_q       <= state_d;
      fault_q       <= fault_d;
      faultCode_q   <= faultCode_d;
      faultDir_q    <= faultDir_d;
      activeDir_q   <= activeDir_d;
      activeValid_q <= activeValid_d;
      for (int i = 0; i < 4; i++) begin
        prev_q[i] <= code[i];
        if (state_q == S_INIT) begin
          dwell_q[i]     <= CNT_W'(1);
          entrySeen_q[i] <= 1'b0;
        end else if (code[i] == prev_q[i]) begin
          if (dwell_q[i] != '1) dwell_q[i] <= dwell_q[i] + CNT_W'(1);
        end else begin
          dwell_q[i]     <= CNT_W'(1);
          entrySeen_q[i] <= 1'b1;
        end
      end
    end
  end

  assign fault        = fault_q;
  assign fault_code   = faultCode_q;
  assign fault_dir    = faultDir_q;
  assign active_dir   = activeDir_q;
  assign active_valid = activeValid_q;

endmodule

// File: tb/tb_signal_conflict_monitor.sv
// Directed bench for signal_conflict_monitor: each step queues the outputs it should produce
// one cycle later, and the popped entry is compared against the registered outputs.
module tb_signal_conflict_monitor;

  logic       clk = 1'b0;
  logic       clear;
  logic [1:0] right, up, down, left;
  logic [3:0] walk;
  logic       fault;
  logic [2:0] fault_code;
  logic [1:0] fault_dir;
  logic [1:0] active_dir;
  logic       active_valid;

  typedef struct {
    logic       f;
    logic [2:0] c;
    logic [1:0] d;
    logic [1:0] ad;
    logic       av;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   stepNo = 0;

  logic       stF;
  logic [2:0] stC;
  logic [1:0] stD;
  logic [1:0] expAd;
  logic [1:0] lamps [4];

  signal_conflict_monitor #(.Y_TIME(2), .MIN_GREEN(10), .CNT_W(8)) dut (
    .clk(clk), .clear(clear), .right(right), .up(up), .down(down), .left(left),
    .walk(walk), .fault(fault), .fault_code(fault_code), .fault_dir(fault_dir),
    .active_dir(active_dir), .active_valid(active_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput();
    exp_t e;
    checks++;
    assert (expQ.size() != 0) else begin
      errors++;
      $error("FAIL step%0d queue: observed=empty expected=entry", stepNo);
      return;
    end
    e = expQ.pop_front();
    checks++;
    assert (fault === e.f) else begin
      errors++; $error("FAIL step%0d fault: observed=%0b expected=%0b", stepNo, fault, e.f);
    end
    checks++;
    assert (fault_code === e.c) else begin
      errors++; $error("FAIL step%0d fault_code: observed=%0d expected=%0d", stepNo, fault_code, e.c);
    end
    checks++;
    assert (fault_dir === e.d) else begin
      errors++; $error("FAIL step%0d fault_dir: observed=%0d expected=%0d", stepNo, fault_dir, e.d);
    end
    checks++;
    assert (active_dir === e.ad) else begin
      errors++; $error("FAIL step%0d active_dir: observed=%0d expected=%0d", stepNo, active_dir, e.ad);
    end
    checks++;
    assert (active_valid === e.av) else begin
      errors++; $error("FAIL step%0d active_valid: observed=%0b expected=%0b", stepNo, active_valid, e.av);
    end
  endtask

  // newCode/newDir: the fault expected to be detected on this sample (0 = none).
  task automatic applyStimulus(input logic [1:0] r, u, d, l, input logic [3:0] w,
                               input logic clr, input logic [2:0] newCode, input logic [1:0] newDir);
    exp_t       e;
    logic [1:0] cs [4];
    int         nGreen;
    logic [1:0] gIdx;
    logic       faultBefore;
    right = r; up = u; down = d; left = l; walk = w; clear = clr;
    cs[0] = r; cs[1] = u; cs[2] = d; cs[3] = l;
    nGreen = 0;
    gIdx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (cs[i] == 2'd2) begin
        nGreen++;
        gIdx = 2'(i);
      end
    end
    if (clr) begin
      stF = 1'b0; stC = 3'd0; stD = 2'd0; expAd = 2'd0;
      e.av = 1'b0;
    end else begin
      faultBefore = stF;
      if (!stF && newCode != 3'd0) begin
        stF = 1'b1; stC = newCode; stD = newDir;
      end
      if (nGreen == 1 && !faultBefore) expAd = gIdx;
      e.av = (nGreen == 1) && !stF;
    end
    e.f = stF; e.c = stC; e.d = stD; e.ad = expAd;
    expQ.push_back(e);
    stepNo++;
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic doClear();
    applyStimulus(2'd0, 2'd0, 2'd0, 2'd0, 4'b0001, 1'b1, 3'd0, 2'd0);
    applyStimulus(2'd0, 2'd0, 2'd0, 2'd0, 4'b0001, 1'b0, 3'd0, 2'd0);
  endtask

  task automatic holdLamps(input int n, input logic [3:0] w);
    for (int k = 0; k < n; k++)
      applyStimulus(lamps[0], lamps[1], lamps[2], lamps[3], w, 1'b0, 3'd0, 2'd0);
  endtask

  initial begin
    stF = 1'b0; stC = 3'd0; stD = 2'd0; expAd = 2'd0;
    clear = 1'b1; right = 2'd0; up = 2'd0; down = 2'd0; left = 2'd0; walk = 4'b0001;

    // Nominal three-rotation run: greens on 1, 2, 3, 0 with exact yellow dwell.
    doClear();
    for (int i = 0; i < 4; i++) lamps[i] = 2'd0;
    for (int rep = 0; rep < 3; rep++) begin
      for (int ph = 0; ph < 4; ph++) begin
        for (int i = 0; i < 4; i++) lamps[i] = 2'd0;
        lamps[(ph + 1) % 4] = 2'd2;
        holdLamps(10, 4'b0001 << ph);
        lamps[(ph + 1) % 4] = 2'd1;
        holdLamps(2, 4'b1000 >> ph);
      end
    end
    for (int i = 0; i < 4; i++) lamps[i] = 2'd0;
    holdLamps(2, 4'b0100);

    // Conflict on up and down, stays latched, then clear.
    doClear();
    applyStimulus(2'd0, 2'd2, 2'd2, 2'd0, 4'b0001, 1'b0, 3'd1, 2'd1);
    applyStimulus(2'd0, 2'd2, 2'd0, 2'd0, 4'b0001, 1'b0, 3'd0, 2'd0);
    applyStimulus(2'd0, 2'd0, 2'd0, 2'd0, 4'b0001, 1'b0, 3'd0, 2'd0);
    applyStimulus(2'd0, 2'd0, 2'd0, 2'd0, 4'b0001, 1'b1, 3'd0, 2'd0);

    // Up green straight to red.
    doClear();
    for (int k = 0; k < 12; k++)
      applyStimulus(2'd0, 2'd2, 2'd0, 2'd0, 4'b0010, 1'b0, 3'd0, 2'd0);
    applyStimulus(2'd0, 2'd0, 2'd0, 2'd0, 4'b0010, 1'b0, 3'd3, 2'd1);
    applyStimulus(2'd0, 2'd0, 2'd0, 2'd0, 4'b0010, 1'b0, 3'd0, 2'd0);

    // Illegal lamp code on left outranks its illegal transition.
    doClear();
    applyStimulus(2'd0, 2'd0, 2'd0, 2'd3, 4'b0001, 1'b0, 3'd2, 2'd3);

    // Short green on left.
    doClear();
    for (int k = 0; k < 6; k++)
      applyStimulus(2'd0, 2'd0, 2'd0, 2'd2, 4'b0100, 1'b0, 3'd0, 2'd0);
    applyStimulus(2'd0, 2'd0, 2'd0, 2'd1, 4'b0100, 1'b0, 3'd4, 2'd3);

    // Over-long yellow on right, flagged only when it ends.
    doClear();
    for (int k = 0; k < 10; k++)
      applyStimulus(2'd2, 2'd0, 2'd0, 2'd0, 4'b0001, 1'b0, 3'd0, 2'd0);
    for (int k = 0; k < 3; k++)
      applyStimulus(2'd1, 2'd0, 2'd0, 2'd0, 4'b0001, 1'b0, 3'd0, 2'd0);
    applyStimulus(2'd0, 2'd0, 2'd0, 2'd0, 4'b0001, 1'b0, 3'd5, 2'd0);
    applyStimulus(2'd0, 2'd0, 2'd0, 2'd0, 4'b0001, 1'b0, 3'd0, 2'd0);

    // Walk not one-hot, alone and together with a conflict.
    doClear();
    applyStimulus(2'd0, 2'd0, 2'd0, 2'd0, 4'b1100, 1'b0, 3'd6, 2'd0);
    applyStimulus(2'd0, 2'd0, 2'd0, 2'd0, 4'b0001, 1'b0, 3'd0, 2'd0);
    doClear();
    applyStimulus(2'd0, 2'd2, 2'd2, 2'd0, 4'b1100, 1'b0, 3'd1, 2'd1);

    // Clear in the middle of down's yellow, then a full clean cycle of down.
    doClear();
    for (int k = 0; k < 10; k++)
      applyStimulus(2'd0, 2'd0, 2'd2, 2'd0, 4'b0100, 1'b0, 3'd0, 2'd0);
    applyStimulus(2'd0, 2'd0, 2'd1, 2'd0, 4'b0100, 1'b1, 3'd0, 2'd0);
    applyStimulus(2'd0, 2'd0, 2'd1, 2'd0, 4'b0100, 1'b0, 3'd0, 2'd0);
    for (int k = 0; k < 3; k++)
      applyStimulus(2'd0, 2'd0, 2'd0, 2'd0, 4'b0100, 1'b0, 3'd0, 2'd0);
    for (int k = 0; k < 10; k++)
      applyStimulus(2'd0, 2'd0, 2'd2, 2'd0, 4'b0100, 1'b0, 3'd0, 2'd0);
    for (int k = 0; k < 2; k++)
      applyStimulus(2'd0, 2'd0, 2'd1, 2'd0, 4'b0100, 1'b0, 3'd0, 2'd0);
    for (int k = 0; k < 2; k++)
      applyStimulus(2'd0, 2'd0, 2'd0, 2'd0, 4'b0100, 1'b0, 3'd0, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
